codiq_chip_sequencer: RTL and testbench
=======================================

CODIQ_CHIP_SEQUENCER -- requirements
Module: codiq_chip_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_CHIP, default 25, meaning clk cycles per chip (50 MHz / 2 Mchip/s).
REQ-002 SHALL have parameter EN_HIGH, default 13, meaning cycles per chip period during which en_2MHz is high.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 50 MHz.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port frame_start, input, 1 bit: one-cycle request to transmit a frame.
REQ-006 SHALL have port frame_len, input, 7 bits: payload byte count, sampled on an accepted frame_start; 0 is legal.
REQ-007 SHALL have port byte_data, input, 8 bits: payload byte.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-009 SHALL have port byte_ready, output, 1 bit: sequencer accepts byte_data; a transfer occurs when byte_valid and byte_ready are both high.
REQ-010 SHALL have port coder_ready, input, 1 bit: ready output of the IQ coder.
REQ-011 SHALL have port dac_ready, input, 1 bit: DAC accepts samples.
REQ-012 SHALL have port b_in, output, 1 bit: current chip value to the coder.
REQ-013 SHALL have port en_2MHz, output, 1 bit: chip strobe to the coder.
REQ-014 SHALL have port mem_state, output, 1 bit: high while a frame is active.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-017 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-018 SHALL implement states IDLE, PREAMBLE, SFD, PHR, PAYLOAD.
REQ-019 IDLE SHALL accept frame_start only while coder_ready=1; frame_start with coder_ready=0 SHALL be ignored.
REQ-020 An accepted start SHALL make the first chip period begin on the next cycle, with mem_state=1 and busy=1.
REQ-021 PREAMBLE SHALL send 8 symbols of value 0; SFD SHALL send byte 0xA7; PHR SHALL send {1'b0, frame_len}; PAYLOAD SHALL send frame_len bytes.
REQ-022 Every byte SHALL be sent low nibble first; each nibble SHALL map to the 32-chip IEEE 802.15.4 sequence, chip c0 first (symbol 0 = 32'hD9C3522E, MSB = c0).
REQ-023 Each chip SHALL last CLK_PER_CHIP cycles, with b_in constant over the period.
REQ-024 en_2MHz SHALL be 1 in cycles 0..EN_HIGH-1 of each chip period and 0 otherwise.
REQ-025 While dac_ready=0 in an active state, the cycle counter, chip index and state SHALL freeze, en_2MHz SHALL be 0, and b_in SHALL hold its value.
REQ-026 The chip period SHALL resume at the frozen count when dac_ready returns to 1.
REQ-027 byte_ready SHALL assert from chip 0 of the last symbol before each payload byte is needed, and SHALL deassert in the cycle after the transfer.
REQ-028 The accepted byte SHALL be held in a one-byte register.
REQ-029 If no transfer has occurred when the next payload symbol must start, the sequencer SHALL pulse underrun, go to IDLE, and drive mem_state=0 and b_in=0.
REQ-030 With frame_len=0, the sequencer SHALL go from PHR directly to the end of frame, and byte_ready SHALL never assert.
REQ-031 At the end of the last chip of the last symbol, done SHALL pulse for one cycle, the state SHALL return to IDLE, and mem_state SHALL drop in the same cycle.
REQ-032 frame_start while busy SHALL be ignored.
REQ-033 Frame duration with dac_ready held at 1 SHALL be (12 + 2*frame_len)*32*CLK_PER_CHIP cycles.
REQ-034 Counters SHALL have these widths: cycle counter ceil(log2(CLK_PER_CHIP)) bits, chip index 5 bits, symbol counter 4 bits, byte counter 7 bits; all wrap to 0 without overflow.

Reset
REQ-035 reset=1 SHALL take priority over all inputs and force state IDLE, all counters 0, and all outputs 0 (b_in, en_2MHz, mem_state, busy, done, underrun, byte_ready) on the next clk edge.
REQ-036 reset asserted mid-frame SHALL abort the frame without a done or underrun pulse.

Structure
REQ-037 Package codiq_pkg SHALL hold the state enum, CHIPS_PER_SYM=32, PREAMBLE_SYMS=8, SFD=8'hA7, and the 16x32 chip table.
REQ-038 Sub-module codiq_chip_rom SHALL be combinational, mapping a 4-bit symbol to its 32-bit chip word.
REQ-039 The sequencer itself SHALL be a single FSM with the counters and the byte register.

Verification
REQ-040 frame_start, frame_len=1, byte 0x00, dac_ready=1 -> mem_state high for exactly 11200 cycles, done pulses once, and all 448 chips decode as symbol 0 except the SFD and PHR symbols.
REQ-041 First chip period after start -> en_2MHz high 13 cycles and low 12 cycles; first 32 b_in values = D9C3522E, MSB first.
REQ-042 dac_ready=0 for 100 cycles mid-chip -> frame lengthens by exactly 100 cycles, en_2MHz=0 throughout the stall, and the chip sequence is unchanged.
REQ-043 frame_len=2 with byte_valid held 0 -> underrun pulses at the first payload symbol boundary, the state returns to IDLE, and done never pulses.
REQ-044 frame_start with coder_ready=0, and frame_start while busy -> both ignored, with no change in state or outputs.
REQ-045 reset pulsed at cycle 5000 of a frame -> all outputs 0 on the next cycle, and a new frame_start afterwards runs a full-length frame.

Source files
------------

// File: rtl/codiq_pkg.sv
// Shared definitions for the chip sequencer: state encoding, frame constants
// and the 16-entry symbol-to-chip table (MSB of each word is chip c0).
package codiq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PHR      = 3'd3,
        ST_PAYLOAD  = 3'd4
    } state_t;

    localparam int         CHIPS_PER_SYM = 32;
    localparam int         PREAMBLE_SYMS = 8;
    localparam logic [7:0] SFD           = 8'hA7;

    localparam logic [31:0] CHIP_TABLE [16] = '{
        32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
        32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
        32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
        32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
    };

endpackage

// File: rtl/codiq_chip_rom.sv
// Combinational symbol-to-chip lookup.
module codiq_chip_rom
    import codiq_pkg::*;
(
    input  logic [3:0]  sym_i,
    output logic [31:0] chips_o
);

    // Pure table lookup, no state.
    always_comb begin
        chips_o = CHIP_TABLE[sym_i];
    end

endmodule

// File: rtl/codiq_chip_sequencer.sv
// Frame sequencer: walks preamble, SFD, PHR and payload symbols, emitting one
// chip per chip period on b_in with an en_2MHz strobe for the IQ coder.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no frame; waits for frame_start while coder_ready is high
// ST_PREAMBLE | eight symbols of value 0
// ST_SFD      | SFD byte, low nibble then high nibble
// ST_PHR      | {1'b0, frame_len}; requests first payload byte in 2nd symbol
// ST_PAYLOAD  | payload bytes from the one-byte holding register
module codiq_chip_sequencer
    import codiq_pkg::*;
#(
    parameter int CLK_PER_CHIP = 25,
    parameter int EN_HIGH      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [6:0] frame_len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       coder_ready,
    input  logic       dac_ready,
    output logic       b_in,
    output logic       en_2MHz,
    output logic       mem_state,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int             CW        = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;
    localparam logic [CW-1:0]  CYC_LAST  = CW'(CLK_PER_CHIP - 1);
    localparam logic [CW:0]    EN_HIGH_C = (CW + 1)'(EN_HIGH);
    localparam logic [4:0]     CHIP_LAST = 5'(CHIPS_PER_SYM - 1);
    localparam logic [3:0]     PRE_LAST  = 4'(PREAMBLE_SYMS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    chip_q, chip_d;
    logic [3:0]    sym_q, sym_d;
    logic [6:0]    byte_cnt_q, byte_cnt_d;
    logic [6:0]    len_q, len_d;
    logic [7:0]    data_q, data_d;
    logic          have_q, have_d;
    logic [3:0]    nib_q, nib_d;
    logic          byte_ready_q, byte_ready_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    logic          active;
    logic          xfer;
    logic          finish;
    logic          abort;
    logic          load_byte;
    logic [31:0]   chip_word;

    // The nibble being sent is latched at each symbol start, so the byte
    // register may be refilled during the high-nibble symbol.
    codiq_chip_rom u_rom (
        .sym_i   (nib_q),
        .chips_o (chip_word)
    );

    assign active     = (state_q != ST_IDLE);
    assign xfer       = byte_valid & byte_ready_q;
    assign mem_state  = active;
    assign busy       = active;
    assign byte_ready = byte_ready_q;
    assign done       = done_q;
    assign underrun   = underrun_q;
    // Chip c0 is the word MSB, so the bit index is 31 - chip, i.e. ~chip.
    assign b_in       = active & chip_word[~chip_q];
    assign en_2MHz    = active & dac_ready & ({1'b0, cyc_q} < EN_HIGH_C);

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        chip_d       = chip_q;
        sym_d        = sym_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        nib_d        = nib_q;
        data_d       = xfer ? byte_data : data_q;
        have_d       = have_q | xfer;
        byte_ready_d = byte_ready_q & ~xfer;
        done_d       = 1'b0;
        underrun_d   = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;
        load_byte    = 1'b0;

        if (state_q == ST_IDLE) begin
            byte_ready_d = 1'b0;
            if (frame_start && coder_ready) begin
                state_d    = ST_PREAMBLE;
                cyc_d      = '0;
                chip_d     = '0;
                sym_d      = '0;
                byte_cnt_d = '0;
                len_d      = frame_len;
                nib_d      = 4'h0;
                have_d     = 1'b0;
            end
        end else if (dac_ready) begin
            if (cyc_q != CYC_LAST) begin
                cyc_d = cyc_q + CW'(1);
            end else begin
                cyc_d  = '0;
                chip_d = chip_q + 5'd1;
                if (chip_q == CHIP_LAST) begin
                    case (state_q)
                        ST_PREAMBLE: begin
                            if (sym_q == PRE_LAST) begin
                                state_d = ST_SFD;
                                sym_d   = '0;
                                nib_d   = SFD[3:0];
                            end else begin
                                sym_d = sym_q + 4'd1;
                            end
                        end
                        ST_SFD: begin
                            if (!sym_q[0]) begin
                                sym_d = 4'd1;
                                nib_d = SFD[7:4];
                            end else begin
                                state_d = ST_PHR;
                                sym_d   = '0;
                                nib_d   = len_q[3:0];
                            end
                        end
                        ST_PHR: begin
                            if (!sym_q[0]) begin
                                sym_d        = 4'd1;
                                nib_d        = {1'b0, len_q[6:4]};
                                byte_ready_d = (len_q != 7'd0);
                            end else if (len_q == 7'd0) begin
                                finish = 1'b1;
                            end else begin
                                load_byte  = 1'b1;
                                byte_cnt_d = '0;
                            end
                        end
                        ST_PAYLOAD: begin
                            if (!sym_q[0]) begin
                                sym_d        = 4'd1;
                                nib_d        = data_q[7:4];
                                byte_ready_d = (byte_cnt_q != len_q - 7'd1);
                            end else if (byte_cnt_q == len_q - 7'd1) begin
                                finish = 1'b1;
                            end else begin
                                load_byte  = 1'b1;
                                byte_cnt_d = byte_cnt_q + 7'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        // A transfer landing on the boundary cycle itself still counts.
        if (load_byte) begin
            if (have_q || xfer) begin
                state_d = ST_PAYLOAD;
                sym_d   = '0;
                nib_d   = data_d[3:0];
                have_d  = 1'b0;
            end else begin
                abort = 1'b1;
            end
        end

        if (finish || abort) begin
            state_d      = ST_IDLE;
            sym_d        = '0;
            byte_cnt_d   = '0;
            nib_d        = 4'h0;
            have_d       = 1'b0;
            byte_ready_d = 1'b0;
            done_d       = finish;
            underrun_d   = abort;
        end
    end

    // State, counters and holding registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            chip_q       <= '0;
            sym_q        <= '0;
            byte_cnt_q   <= '0;
            len_q        <= '0;
            data_q       <= '0;
            have_q       <= 1'b0;
            nib_q        <= '0;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            chip_q       <= chip_d;
            sym_q        <= sym_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            data_q       <= data_d;
            have_q       <= have_d;
            nib_q        <= nib_d;
            byte_ready_q <= byte_ready_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_codiq_chip_sequencer.sv
// Directed bench for codiq_chip_sequencer: frames of several lengths, DAC
// stall, payload underrun, ignored starts and mid-frame reset.
module tb_codiq_chip_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [6:0] frame_len = 7'd0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       coder_ready = 1'b1;
    logic       dac_ready = 1'b1;
    logic       b_in, en_2MHz, mem_state, busy, done, underrun;

    int vec  = 0;
    int miss = 0;

    localparam logic [31:0] REF_CHIPS [16] = '{
        32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
        32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
        32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
        32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
    };

    // capture results
    int          act, done_cnt, und_cnt, en_err, bin_err, first_hi;
    int          br_first, br_cycles, nchips;
    logic [31:0] words [16];
    logic [7:0]  bq [4];
    logic [3:0]  es [16];
    int          ns;

    codiq_chip_sequencer #(.CLK_PER_CHIP(25), .EN_HIGH(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .coder_ready (coder_ready),
        .dac_ready   (dac_ready),
        .b_in        (b_in),
        .en_2MHz     (en_2MHz),
        .mem_state   (mem_state),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected symbol list: preamble, SFD, PHR, then nb payload bytes.
    task automatic build_exp(input logic [6:0] len, input int nb);
        for (int i = 0; i < 8; i++) es[i] = 4'h0;
        es[8]  = 4'h7;
        es[9]  = 4'hA;
        es[10] = len[3:0];
        es[11] = {1'b0, len[6:4]};
        for (int i = 0; i < nb; i++) begin
            es[12 + 2*i] = bq[i][3:0];
            es[13 + 2*i] = bq[i][7:4];
        end
        ns = 12 + 2*nb;
    endtask

    task automatic start_frame(input logic [6:0] len);
        frame_len   = len;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Runs the frame cycle by cycle with an independent chip-period model;
    // returns at the first sample where mem_state is low.
    task automatic capture(input int nbytes, input int stall_at, input int stall_len,
                           input int busy_at);
        int   pos, k, n;
        logic cur, new_chip;
        act = 0; done_cnt = 0; und_cnt = 0; en_err = 0; bin_err = 0; first_hi = 0;
        br_first = -1; br_cycles = 0; nchips = 0;
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        pos = 0; k = 0; n = 0; cur = 1'b0; new_chip = 1'b1;
        while (n < 20000) begin
            dac_ready   = !(n >= stall_at && n < stall_at + stall_len);
            frame_start = (n == busy_at);
            if (n == busy_at) frame_len = 7'd5;
            byte_valid  = (k < nbytes);
            byte_data   = (k < nbytes) ? bq[k] : 8'h00;
            #1;
            if (done) done_cnt++;
            if (underrun) und_cnt++;
            if (!mem_state) break;
            act++;
            if (byte_ready) begin
                br_cycles++;
                if (br_first < 0) br_first = n;
            end
            if (n < 25 && en_2MHz) first_hi++;
            if (en_2MHz !== (dac_ready && pos < 13)) en_err++;
            if (new_chip) begin
                if (nchips < 512) words[nchips / 32][31 - (nchips % 32)] = b_in;
                cur = b_in;
                new_chip = 1'b0;
            end else if (b_in !== cur) begin
                bin_err++;
            end
            if (byte_valid && byte_ready) k++;
            if (dac_ready) begin
                pos++;
                if (pos == 25) begin
                    pos = 0;
                    nchips++;
                    new_chip = 1'b1;
                end
            end
            n++;
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
        dac_ready   = 1'b1;
        byte_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({b_in, en_2MHz, mem_state, busy, done, underrun, byte_ready} !== 7'b0) begin
            miss++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {b_in, en_2MHz, mem_state, busy, done, underrun, byte_ready});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte();
        bq[0] = 8'h00;
        build_exp(7'd1, 1);
        start_frame(7'd1);
        capture(1, -1, 0, -1);
        vec++; if (act !== 11200) begin miss++; $display("FAIL len1_duration got %0d exp 11200", act); end
        vec++; if (done_cnt !== 1) begin miss++; $display("FAIL len1_done got %0d exp 1", done_cnt); end
        vec++; if (first_hi !== 13) begin miss++; $display("FAIL first_period_en_high got %0d exp 13", first_hi); end
        vec++; if (en_err !== 0) begin miss++; $display("FAIL len1_en_pattern got %0d bad cycles exp 0", en_err); end
        vec++; if (bin_err !== 0) begin miss++; $display("FAIL len1_bin_stable got %0d changes exp 0", bin_err); end
        vec++; if (words[0] !== 32'hD9C3522E) begin miss++; $display("FAIL first_32_chips got %h exp d9c3522e", words[0]); end
        vec++; if (br_first !== 8800) begin miss++; $display("FAIL len1_byte_ready_start got %0d exp 8800", br_first); end
        vec++; if (br_cycles !== 1) begin miss++; $display("FAIL len1_byte_ready_len got %0d exp 1", br_cycles); end
        for (int i = 0; i < ns; i++) begin
            vec++;
            if (words[i] !== REF_CHIPS[es[i]]) begin
                miss++;
                $display("FAIL len1_symbol_%0d got %h exp %h", i, words[i], REF_CHIPS[es[i]]);
            end
        end
        @(posedge clk); #1;
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL done_one_cycle got %b exp 0", done); end
    endtask

    task automatic test_two_bytes();
        bq[0] = 8'h3C;
        bq[1] = 8'h5E;
        build_exp(7'd2, 2);
        start_frame(7'd2);
        capture(2, -1, 0, -1);
        vec++; if (act !== 12800) begin miss++; $display("FAIL len2_duration got %0d exp 12800", act); end
        vec++; if (done_cnt !== 1) begin miss++; $display("FAIL len2_done got %0d exp 1", done_cnt); end
        vec++; if (br_cycles !== 2) begin miss++; $display("FAIL len2_byte_ready_len got %0d exp 2", br_cycles); end
        for (int i = 0; i < ns; i++) begin
            vec++;
            if (words[i] !== REF_CHIPS[es[i]]) begin
                miss++;
                $display("FAIL len2_symbol_%0d got %h exp %h", i, words[i], REF_CHIPS[es[i]]);
            end
        end
    endtask

    // Starts in the done cycle of the previous frame (back-to-back).
    task automatic test_dac_stall();
        build_exp(7'd0, 0);
        start_frame(7'd0);
        capture(0, 1010, 100, -1);
        vec++; if (act !== 9700) begin miss++; $display("FAIL stall_duration got %0d exp 9700", act); end
        vec++; if (en_err !== 0) begin miss++; $display("FAIL stall_en got %0d bad cycles exp 0", en_err); end
        vec++; if (bin_err !== 0) begin miss++; $display("FAIL stall_bin_hold got %0d changes exp 0", bin_err); end
        vec++; if (br_cycles !== 0) begin miss++; $display("FAIL len0_byte_ready got %0d exp 0", br_cycles); end
        vec++; if (done_cnt !== 1) begin miss++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
        for (int i = 0; i < ns; i++) begin
            vec++;
            if (words[i] !== REF_CHIPS[es[i]]) begin
                miss++;
                $display("FAIL stall_symbol_%0d got %h exp %h", i, words[i], REF_CHIPS[es[i]]);
            end
        end
    endtask

    task automatic test_underrun();
        start_frame(7'd2);
        capture(0, -1, 0, -1);
        vec++; if (act !== 9600) begin miss++; $display("FAIL underrun_time got %0d exp 9600", act); end
        vec++; if (und_cnt !== 1) begin miss++; $display("FAIL underrun_pulse got %0d exp 1", und_cnt); end
        vec++; if (done_cnt !== 0) begin miss++; $display("FAIL underrun_no_done got %0d exp 0", done_cnt); end
        vec++; if (br_cycles !== 800) begin miss++; $display("FAIL underrun_byte_ready got %0d exp 800", br_cycles); end
        vec++; if ({b_in, busy} !== 2'b00) begin miss++; $display("FAIL underrun_idle got %b exp 00", {b_in, busy}); end
        @(posedge clk); #1;
        vec++; if (underrun !== 1'b0) begin miss++; $display("FAIL underrun_one_cycle got %b exp 0", underrun); end
    endtask

    task automatic test_ignored_starts();
        coder_ready = 1'b0;
        start_frame(7'd3);
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({mem_state, busy, en_2MHz, b_in} !== 4'b0) begin
            miss++;
            $display("FAIL coder_not_ready_start got %b exp 0000", {mem_state, busy, en_2MHz, b_in});
        end
        coder_ready = 1'b1;
        build_exp(7'd0, 0);
        start_frame(7'd0);
        capture(0, -1, 0, 3000);
        vec++; if (act !== 9600) begin miss++; $display("FAIL busy_start_duration got %0d exp 9600", act); end
        vec++; if (done_cnt !== 1) begin miss++; $display("FAIL busy_start_done got %0d exp 1", done_cnt); end
        vec++; if (words[10] !== REF_CHIPS[es[10]]) begin miss++; $display("FAIL busy_start_phr got %h exp %h", words[10], REF_CHIPS[es[10]]); end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(7'd1);
        repeat (5000) @(posedge clk);
        #1;
        vec++; if (mem_state !== 1'b1) begin miss++; $display("FAIL pre_reset_active got %b exp 1", mem_state); end
        reset = 1'b1;
        @(posedge clk); #1;
        vec++;
        if ({b_in, en_2MHz, mem_state, busy, done, underrun, byte_ready} !== 7'b0) begin
            miss++;
            $display("FAIL mid_reset_outputs got %b exp 0000000",
                     {b_in, en_2MHz, mem_state, busy, done, underrun, byte_ready});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vec++; if ({done, underrun} !== 2'b00) begin miss++; $display("FAIL mid_reset_no_pulse got %b exp 00", {done, underrun}); end
        start_frame(7'd0);
        capture(0, -1, 0, -1);
        vec++; if (act !== 9600) begin miss++; $display("FAIL post_reset_duration got %0d exp 9600", act); end
        vec++; if (done_cnt !== 1) begin miss++; $display("FAIL post_reset_done got %0d exp 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_bytes();
        test_dac_stall();
        test_underrun();
        test_ignored_starts();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
